// File: rtl/bus_req_arbiter.sv
// -----------------------------------------------------------------------------
// bus_req_arbiter
//
// Round-robin arbiter that shares the coherence bus controller among the CPUS
// L1 caches (I and D caches of every hart). It grants one cache at a time and
// holds that grant until the bus controller reports completion or the granted
// core aborts. A one-cycle release bubble follows every grant. The search for
// the next winner starts just after the last winner, so every requester is
// served within CPUS transactions.
//
// Optional feature macro: BUS_ARB_PERF_CNT_EN
//   When it is defined, the block gains a per-requester saturating grant
//   counter, exposed on grant_count. When it is undefined, the port and the
//   counter logic are absent. Arbitration behaviour is the same in both builds.
//
// Ports:
//   CLK            in   system clock; all state changes on the rising edge
//   RST            in   asynchronous, active-high reset
//   req_ren        in   [CPUS]  per-cache read request
//   req_wen        in   [CPUS]  per-cache write/evict request
//   ccabort        in   [CPUS]  per-core abort of an outstanding request
//   xfer_done      in   one-cycle completion pulse from the bus controller
//   grant_valid    out  a grant is active
//   grant_id       out  [ID_W]  index of the granted requester
//   grant_onehot   out  [CPUS]  one-hot of grant_id; zero when no grant
//   grant_is_write out  the granted request was a write (latched at grant)
//   arb_busy       out  arbiter is not idle
//   grant_count    out  [CPUS*CNT_WIDTH] grants per requester; requester i
//                       occupies bits [i*CNT_WIDTH +: CNT_WIDTH]
//                       (BUS_ARB_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module bus_req_arbiter #(
    parameter int NUM_HARTS = 2,
    parameter int CPUS      = NUM_HARTS * 2,
    parameter int CNT_WIDTH = 16,
    parameter int ID_W      = $clog2(CPUS)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CPUS-1:0]           req_ren,
    input  logic [CPUS-1:0]           req_wen,
    input  logic [CPUS-1:0]           ccabort,
    input  logic                      xfer_done,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id,
    output logic [CPUS-1:0]           grant_onehot,
    output logic                      grant_is_write,
    output logic                      arb_busy
`ifdef BUS_ARB_PERF_CNT_EN
    ,
    output logic [CPUS*CNT_WIDTH-1:0] grant_count
`endif
);

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    arb_state_t        state_r;
    logic [ID_W-1:0]   last_id_r;
    logic              grant_valid_r;
    logic [ID_W-1:0]   grant_id_r;
    logic [CPUS-1:0]   grant_onehot_r;
    logic              grant_is_write_r;
    logic              arb_busy_r;

    logic [CPUS-1:0]   req_s;
    logic [ID_W-1:0]   winner_s;
    logic              winner_found_s;
    logic              scan_hit_s;
    int unsigned       scan_idx_s;
    logic              release_s;
    logic              grant_now_s;

    // Round-robin search: first requester at or above last_id+1, with wrap-around.
    always_comb begin
        req_s          = req_ren | req_wen;
        winner_s       = '0;
        winner_found_s = 1'b0;
        scan_hit_s     = 1'b0;
        scan_idx_s     = 0;
        for (int k = 1; k <= CPUS; k++) begin
            scan_idx_s     = (int'(last_id_r) + k) % CPUS;
            scan_hit_s     = !winner_found_s && req_s[scan_idx_s];
            winner_s       = scan_hit_s ? ID_W'(scan_idx_s) : winner_s;
            winner_found_s = winner_found_s | scan_hit_s;
        end
    end

    // Completion and abort by the granted core lead to the same release, so
    // they are simply ORed. Aborts from other requesters are not looked at.
    always_comb begin
        release_s   = xfer_done || ccabort[grant_id_r];
        grant_now_s = (state_r == ARB_IDLE) && winner_found_s;
    end

    // Arbitration FSM with all grant outputs registered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r          <= ARB_IDLE;
            last_id_r        <= ID_W'(CPUS - 1);
            grant_valid_r    <= 1'b0;
            grant_id_r       <= '0;
            grant_onehot_r   <= '0;
            grant_is_write_r <= 1'b0;
            arb_busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (winner_found_s) begin
                        state_r          <= ARB_GRANT;
                        last_id_r        <= winner_s;
                        grant_valid_r    <= 1'b1;
                        grant_id_r       <= winner_s;
                        grant_onehot_r   <= {{(CPUS-1){1'b0}}, 1'b1} << winner_s;
                        // A read and a write asserted together count as a write.
                        grant_is_write_r <= req_wen[winner_s];
                        arb_busy_r       <= 1'b1;
                    end else begin
                        state_r        <= ARB_IDLE;
                        grant_valid_r  <= 1'b0;
                        grant_onehot_r <= '0;
                        arb_busy_r     <= 1'b0;
                    end
                end
                ARB_GRANT: begin
                    // The grant stays in place until release, even if the
                    // granted cache drops its request early.
                    if (release_s) begin
                        state_r        <= ARB_RELEASE;
                        grant_valid_r  <= 1'b0;
                        grant_onehot_r <= '0;
                        arb_busy_r     <= 1'b1;
                    end else begin
                        state_r        <= ARB_GRANT;
                        grant_valid_r  <= 1'b1;
                        arb_busy_r     <= 1'b1;
                    end
                end
                ARB_RELEASE: begin
                    // This bubble gives the finished cache one cycle to deassert its request.
                    state_r        <= ARB_IDLE;
                    grant_valid_r  <= 1'b0;
                    grant_onehot_r <= '0;
                    arb_busy_r     <= 1'b0;
                end
                default: begin
                    state_r        <= ARB_IDLE;
                    grant_valid_r  <= 1'b0;
                    grant_onehot_r <= '0;
                    arb_busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign grant_valid    = grant_valid_r;
    assign grant_id       = grant_id_r;
    assign grant_onehot   = grant_onehot_r;
    assign grant_is_write = grant_is_write_r;
    assign arb_busy       = arb_busy_r;

`ifdef BUS_ARB_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] grant_cnt_r [CPUS];

    // Per-requester grant counters. They saturate at all-ones and only reset clears them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < CPUS; i++) begin
                grant_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CPUS; i++) begin
                if (grant_now_s && (winner_s == ID_W'(i)) &&
                    (grant_cnt_r[i] != {CNT_WIDTH{1'b1}})) begin
                    grant_cnt_r[i] <= grant_cnt_r[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    grant_cnt_r[i] <= grant_cnt_r[i];
                end
            end
        end
    end

    // Flatten the counter array onto the output port.
    always_comb begin
        grant_count = '0;
        for (int i = 0; i < CPUS; i++) begin
            grant_count[i*CNT_WIDTH +: CNT_WIDTH] = grant_cnt_r[i];
        end
    end
`endif

endmodule

// File: tb/tb_bus_req_arbiter.sv
module tb_bus_req_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] req_ren;
    logic [3:0] req_wen;
    logic [3:0] ccabort;
    logic       xfer_done;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [3:0] grant_onehot;
    logic       grant_is_write;
    logic       arb_busy;
`ifdef BUS_ARB_PERF_CNT_EN
    logic [7:0] grant_count;
`endif

    int total = 0;
    int bad   = 0;
    int m_last = 3;   // model: most recent winner (3 after reset)

    bus_req_arbiter #(.NUM_HARTS(2), .CPUS(4), .CNT_WIDTH(2)) dut (
        .CLK(CLK), .RST(RST),
        .req_ren(req_ren), .req_wen(req_wen), .ccabort(ccabort),
        .xfer_done(xfer_done),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .grant_onehot(grant_onehot), .grant_is_write(grant_is_write),
        .arb_busy(arb_busy)
`ifdef BUS_ARB_PERF_CNT_EN
        , .grant_count(grant_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference rule: the winner is the requester with the smallest cyclic
    // distance past the previous winner.
    function automatic int rr_pick(input logic [3:0] req, input int last);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = 4;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
                d = (i - last - 1 + 8) % 4;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; req_ren = 4'b0; req_wen = 4'b0; ccabort = 4'b0; xfer_done = 1'b0;
        step(); step();
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rst_gv got=%0b want=0", grant_valid); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_gid got=%0d want=0", grant_id); end
        total++; if (grant_onehot !== 4'b0) begin bad++; $display("FAIL rst_oh got=%b want=0000", grant_onehot); end
        total++; if (grant_is_write !== 1'b0) begin bad++; $display("FAIL rst_wr got=%0b want=0", grant_is_write); end
        total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", arb_busy); end
        RST = 1'b0;
        m_last = 3;
        step();
        req_ren = 4'b1111;
        step();
        total++; if (grant_valid !== 1'b1 || grant_id !== 2'd0 || grant_onehot !== 4'b0001 || grant_is_write !== 1'b0)
            begin bad++; $display("FAIL first_grant got=%0b/%0d/%b/%0b want=1/0/0001/0", grant_valid, grant_id, grant_onehot, grant_is_write); end
        m_last = 0;
    endtask

    task automatic test_rotation();
        int exp;
        logic [3:0] oh;
        for (int n = 0; n < 4; n++) begin
            xfer_done = 1'b1; step(); xfer_done = 1'b0;
            total++; if (grant_valid !== 1'b0 || grant_onehot !== 4'b0 || arb_busy !== 1'b1)
                begin bad++; $display("FAIL rot_bubble got=%0b/%b/%0b want=0/0000/1", grant_valid, grant_onehot, arb_busy); end
            step();
            total++; if (grant_valid !== 1'b0 || arb_busy !== 1'b0)
                begin bad++; $display("FAIL rot_idle got=%0b/%0b want=0/0", grant_valid, arb_busy); end
            step();
            exp = rr_pick(4'b1111, m_last); m_last = exp; oh = 4'b0001 << exp;
            total++; if (grant_valid !== 1'b1 || grant_id !== 2'(exp) || grant_onehot !== oh)
                begin bad++; $display("FAIL rot_grant got=%0b/%0d/%b want=1/%0d/%b", grant_valid, grant_id, grant_onehot, exp, oh); end
        end
        req_ren = 4'b0;
        xfer_done = 1'b1; step(); xfer_done = 1'b0; step();
    endtask

    task automatic test_write();
        int exp;
        req_ren = 4'b0100; req_wen = 4'b0100;
        step();
        exp = rr_pick(4'b0100, m_last); m_last = exp;
        total++; if (grant_id !== 2'(exp) || grant_is_write !== 1'b1 || grant_valid !== 1'b1)
            begin bad++; $display("FAIL wr_grant got=%0d/%0b want=%0d/1", grant_id, grant_is_write, exp); end
        req_wen = 4'b0;
        step();
        total++; if (grant_is_write !== 1'b1 || grant_valid !== 1'b1)
            begin bad++; $display("FAIL wr_hold got=%0b/%0b want=1/1", grant_is_write, grant_valid); end
        req_ren = 4'b0;
        xfer_done = 1'b1; step(); xfer_done = 1'b0; step();
    endtask

    task automatic test_abort_and_reset();
        int exp;
        req_ren = 4'b0010;
        step();
        exp = rr_pick(4'b0010, m_last); m_last = exp;
        total++; if (grant_id !== 2'd1 || grant_valid !== 1'b1)
            begin bad++; $display("FAIL ab_setup got=%0d want=1", grant_id); end
        req_ren = 4'b1111; ccabort = 4'b1000;
        step();
        total++; if (grant_valid !== 1'b1 || grant_id !== 2'd1 || arb_busy !== 1'b1)
            begin bad++; $display("FAIL ab_other got=%0b/%0d want=1/1", grant_valid, grant_id); end
        ccabort = 4'b0010;
        step(); ccabort = 4'b0;
        total++; if (grant_valid !== 1'b0 || arb_busy !== 1'b1)
            begin bad++; $display("FAIL ab_release got=%0b/%0b want=0/1", grant_valid, arb_busy); end
        step(); step();
        exp = rr_pick(4'b1111, m_last); m_last = exp;
        total++; if (grant_id !== 2'(exp) || grant_valid !== 1'b1)
            begin bad++; $display("FAIL ab_next got=%0d want=%0d", grant_id, exp); end
        // completion and abort together: one release, one rotation
        xfer_done = 1'b1; ccabort = 4'b0001 << exp;
        step(); xfer_done = 1'b0; ccabort = 4'b0;
        total++; if (grant_valid !== 1'b0 || arb_busy !== 1'b1)
            begin bad++; $display("FAIL both_release got=%0b/%0b want=0/1", grant_valid, arb_busy); end
        step(); step();
        exp = rr_pick(4'b1111, m_last); m_last = exp;
        total++; if (grant_id !== 2'(exp) || grant_valid !== 1'b1)
            begin bad++; $display("FAIL both_next got=%0d want=%0d", grant_id, exp); end
        // asynchronous reset in the middle of a grant
        #2; RST = 1'b1; #1;
        total++; if (grant_valid !== 1'b0 || arb_busy !== 1'b0 || grant_onehot !== 4'b0)
            begin bad++; $display("FAIL async_rst got=%0b/%0b/%b want=0/0/0000", grant_valid, arb_busy, grant_onehot); end
        step(); RST = 1'b0; m_last = 3;
        step();
        total++; if (grant_id !== 2'd0 || grant_valid !== 1'b1)
            begin bad++; $display("FAIL post_rst got=%0d/%0b want=0/1", grant_id, grant_valid); end
        m_last = 0;
        req_ren = 4'b0;
        xfer_done = 1'b1; step(); xfer_done = 1'b0; step();
    endtask

    task automatic test_random();
        int exp;
        int mode;
        logic [3:0] wv;
        logic [3:0] oh;
        logic [3:0] ab;
        for (int it = 0; it < 40; it++) begin
            req_ren = 4'($urandom); req_wen = 4'($urandom);
            if ((req_ren | req_wen) == 4'b0) req_ren[$urandom_range(3, 0)] = 1'b1;
            wv = req_wen;
            exp = rr_pick(req_ren | req_wen, m_last); m_last = exp; oh = 4'b0001 << exp;
            step();
            total++; if (grant_valid !== 1'b1 || grant_id !== 2'(exp) || grant_onehot !== oh || grant_is_write !== wv[exp])
                begin bad++; $display("FAIL rnd_grant it=%0d got=%0d/%b/%0b want=%0d/%b/%0b", it, grant_id, grant_onehot, grant_is_write, exp, oh, wv[exp]); end
            for (int h = 0; h < $urandom_range(2, 0); h++) begin
                req_ren = 4'($urandom); req_wen = 4'($urandom);
                ab = 4'($urandom); ab[exp] = 1'b0; ccabort = ab;
                step();
                total++; if (grant_valid !== 1'b1 || grant_id !== 2'(exp) || grant_is_write !== wv[exp])
                    begin bad++; $display("FAIL rnd_hold it=%0d got=%0b/%0d want=1/%0d", it, grant_valid, grant_id, exp); end
            end
            mode = $urandom_range(2, 0);
            xfer_done = (mode != 1);
            ccabort = (mode != 0) ? oh : 4'b0;
            req_ren = 4'b0; req_wen = 4'b0;
            step();
            xfer_done = 1'($urandom_range(1, 0)); ccabort = 4'b0;
            total++; if (grant_valid !== 1'b0 || arb_busy !== 1'b1 || grant_id !== 2'(exp) || grant_onehot !== 4'b0)
                begin bad++; $display("FAIL rnd_release it=%0d got=%0b/%0b/%0d want=0/1/%0d", it, grant_valid, arb_busy, grant_id, exp); end
            step();
            xfer_done = 1'b0;
            total++; if (grant_valid !== 1'b0 || arb_busy !== 1'b0)
                begin bad++; $display("FAIL rnd_idle it=%0d got=%0b/%0b want=0/0", it, grant_valid, arb_busy); end
        end
    endtask

`ifdef BUS_ARB_PERF_CNT_EN
    task automatic test_counter();
        RST = 1'b1; step(); RST = 1'b0; m_last = 3;
        for (int n = 0; n < 5; n++) begin
            req_ren = 4'b0001; step();
            req_ren = 4'b0;
            xfer_done = 1'b1; step(); xfer_done = 1'b0; step();
            if (n == 1) begin
                total++; if (grant_count !== 8'b0000_0010)
                    begin bad++; $display("FAIL cnt_two got=%b want=00000010", grant_count); end
            end
        end
        total++; if (grant_count !== 8'b0000_0011)
            begin bad++; $display("FAIL cnt_sat got=%b want=00000011", grant_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_write();
        test_abort_and_reset();
        test_random();
`ifdef BUS_ARB_PERF_CNT_EN
        test_counter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
